// File: rtl/tpu_scratchpad_if.sv
// tpu_scratchpad_if: host request (valid/ready) and read-response (rvalid/rready) channel of tpu_scratchpad.
interface tpu_scratchpad_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic valid, ready, we, rvalid, rready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  modport master (output valid, we, addr, wdata, rready, input ready, rvalid, rdata);
  modport slave (input valid, we, addr, wdata, rready, output ready, rvalid, rdata);
endinterface

// File: rtl/tpu_scratchpad.sv
// tpu_scratchpad: operand/result scratchpad with vector and weight read channels, result write port and host port.
// Define TPU_SCRATCHPAD_FWD_EN to forward same-cycle write data to reads; otherwise reads return old data.
module tpu_scratchpad #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int DEPTH = 64,
  parameter int NUM_RD = 3,
  parameter logic [ADDR_W-1:0] ZERO_ADDR = 10'h355
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [ADDR_W-1:0]              l_rd_addr,
  output logic [DATA_W-1:0]              l_rd_data,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  t_rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  t_rd_data,
  input  logic                           w_en,
  input  logic [ADDR_W-1:0]              w_addr,
  input  logic [DATA_W-1:0]              w_data,
  tpu_scratchpad_if.slave                host,
  output logic                           oob_err,
  output logic [15:0]                    host_wr_cnt
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic acc, h_wr, h_rd, oob_any;
  // ZERO_ADDR may sit above DEPTH; it is a legal reserved address, never an error
  function automatic logic oob(input logic [ADDR_W-1:0] a);
    return a != ZERO_ADDR && {1'b0, a} >= DEPTH_L;
  endfunction
  function automatic logic ok(input logic [ADDR_W-1:0] a);
    return a != ZERO_ADDR && {1'b0, a} < DEPTH_L;
  endfunction
`ifdef TPU_SCRATCHPAD_FWD_EN
  logic fwd_en;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
  assign fwd_en = w_en || h_wr;
  assign fwd_addr = w_en ? w_addr : host.addr;
  assign fwd_data = w_en ? w_data : host.wdata;
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    return !ok(a) ? '0 : (fwd_en && a == fwd_addr) ? fwd_data : mem[a[IDX_W-1:0]];
  endfunction
`else
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    return ok(a) ? mem[a[IDX_W-1:0]] : '0;
  endfunction
`endif
  assign host.ready = !w_en && !(host.rvalid && !host.rready);
  assign host.rvalid = state == RESP;
  assign acc = host.valid && host.ready;
  assign h_wr = acc && host.we;
  assign h_rd = acc && !host.we;
  always_comb begin
    oob_any = oob(l_rd_addr) || (w_en && oob(w_addr)) || (acc && oob(host.addr));
    for (int i = 0; i < NUM_RD; i++) oob_any = oob_any || oob(t_rd_addr[i]);
  end
  always_ff @(posedge clk)
    if (w_en && ok(w_addr)) mem[w_addr[IDX_W-1:0]] <= w_data;
    else if (h_wr && ok(host.addr)) mem[host.addr[IDX_W-1:0]] <= host.wdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      l_rd_data <= '0;
      t_rd_data <= '0;
      host.rdata <= '0;
      state <= IDLE;
      oob_err <= 1'b0;
      host_wr_cnt <= '0;
    end else begin
      l_rd_data <= rd(l_rd_addr);
      for (int i = 0; i < NUM_RD; i++) t_rd_data[i] <= rd(t_rd_addr[i]);
      if (oob_any) oob_err <= 1'b1;
      if (h_wr) host_wr_cnt <= host_wr_cnt + 16'd1;
      if (h_rd) begin
        state <= RESP;
        host.rdata <= rd(host.addr);
      end else if (host.rready) state <= IDLE;
    end
endmodule
